// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, byte width, bus mode and the
// debug view exported by the slave.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_BYTE_W = 8;

    // {CPOL, CPHA}; mode 0 means sck idles low and data is sampled on the rise.
    localparam logic [1:0] SPI_MODE = 2'd0;

    typedef struct packed {
        state_t     state;
        logic [2:0] bit_cnt;
        logic       hold_full;
        logic       sck_s;
        logic       cs_s;
    } dbg_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_if.sv
// SPI pins plus the system-side transmit/receive/status signals of the slave.
interface spi_if;
    import spi_pkg::*;

    logic                  sck;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;

    // tx_valid/tx_ready: a byte transfers on every sysclk rising edge where
    // both are high; tx_valid may be raised at any time and tx_data must stay
    // stable while tx_valid is high and tx_ready is low.
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [15:0]           byte_count;
    logic                  busy;
    logic                  tx_underrun;
    logic                  frame_abort;

    modport slave (
        input  sck, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid,
               byte_count, busy, tx_underrun, frame_abort
    );

    modport master (
        output sck, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid,
               byte_count, busy, tx_underrun, frame_abort
    );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous input, with rise/fall pulses taken
// against one further registered copy of the synchronized level.
module spi_sync_edge #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] chain;
    logic         prev;

    // Preset to the line's idle level so leaving reset never fakes an edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            chain <= {N{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[N-2:0], d};
            prev  <= chain[N-1];
        end
    end

    assign q    = chain[N-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, LSB first, 8-bit bytes, oversampled by sysclk, with a
// one-entry transmit holding register in front of the tx shift register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = 8'h00
) (
    input  logic sysclk,
    input  logic rst,
    spi_if.slave bus,
    output dbg_t dbg
);

    localparam logic       SCK_IDLE = SPI_MODE[1];
    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    state_t state, state_nxt;
    logic   busy, start, stop, rx_edge, tx_edge;

    logic       load_now, shift_now, accept, load_under;
    logic [7:0] load_val;
    logic [7:0] rx_next;

    logic [2:0]  bit_cnt;
    logic        byte_done;
    logic [15:0] byte_count;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [6:0]  tx_rest;
    logic        miso, miso_oe;
    logic        hold_full;
    logic [7:0]  hold_data;
    logic        tx_underrun, frame_abort;

    spi_sync_edge #(.N(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .d      (bus.sck),
        .q      (sck_s),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    spi_sync_edge #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .sysclk (sysclk),
        .rst    (rst),
        .d      (bus.cs_n),
        .q      (cs_s),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    // Same depth as the sck chain, so mosi_s is aligned with the detected rise.
    always_ff @(posedge sysclk) begin
        if (rst) mosi_chain <= '0;
        else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    always_ff @(posedge sysclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ACTIVE);
        start   = (state == IDLE) && cs_fall;
        stop    = (state == ACTIVE) && cs_rise;
        rx_edge = (state == ACTIVE) && !cs_rise && sck_rise;
        tx_edge = (state == ACTIVE) && !cs_rise && sck_fall;
        dbg     = '{state: state, bit_cnt: bit_cnt, hold_full: hold_full,
                    sck_s: sck_s, cs_s: cs_s};
    end

    assign accept    = bus.tx_valid & ~hold_full;
    assign load_now  = start | (tx_edge && (bit_cnt == 3'd0) && byte_done);
    assign shift_now = tx_edge && (bit_cnt != 3'd0);
    assign rx_next   = {mosi_s, rx_shift};

    // A byte arriving in the reload cycle bypasses the holding register.
    always_comb begin
        load_val   = IDLE_FILL;
        load_under = 1'b0;
        if (hold_full)   load_val = hold_data;
        else if (accept) load_val = bus.tx_data;
        else             load_under = load_now;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            byte_count  <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_rest     <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            miso_oe     <= ~cs_s;

            if (!busy && !start) miso <= 1'b0;

            if (load_now) begin
                tx_rest     <= load_val[7:1];
                miso        <= load_val[0];
                hold_full   <= 1'b0;
                tx_underrun <= load_under;
                byte_done   <= 1'b0;
            end else begin
                if (accept) begin
                    hold_full <= 1'b1;
                    hold_data <= bus.tx_data;
                end
                if (shift_now) begin
                    miso    <= tx_rest[0];
                    tx_rest <= {1'b0, tx_rest[6:1]};
                end
            end

            if (start) begin
                bit_cnt    <= '0;
                byte_count <= '0;
            end

            if (rx_edge) begin
                rx_shift <= rx_next[7:1];
                if (bit_cnt == LAST_BIT) begin
                    rx_data    <= rx_next;
                    rx_valid   <= 1'b1;
                    byte_count <= sat_inc16(byte_count);
                    bit_cnt    <= '0;
                    byte_done  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end

            // Holding register is deliberately left untouched at frame end.
            if (stop) begin
                frame_abort <= (bit_cnt != 3'd0);
                bit_cnt     <= '0;
                byte_done   <= 1'b0;
                miso        <= 1'b0;
            end
        end
    end

    assign bus.miso        = miso;
    assign bus.miso_oe     = miso_oe;
    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.byte_count  = byte_count;
    assign bus.busy        = busy;
    assign bus.tx_underrun = tx_underrun;
    assign bus.frame_abort = frame_abort;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a byte-level model predicts miso bytes,
// received bytes and status pulses; a per-cycle monitor checks them.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int         SYNC = 2;
    localparam logic [7:0] FILL = 8'h00;
    localparam int         HALF = 8;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    dbg_t dbg;
    spi_if bus();

    spi_slave #(.SYNC_STAGES(SYNC), .IDLE_FILL(FILL)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus),
        .dbg    (dbg)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] cur_tx;
    int exp_under = 0, exp_abort = 0, frame_bytes = 0;
    int under_seen = 0, abort_seen = 0, rx_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Next byte the slave must shift out: oldest accepted byte, else the fill.
    function automatic logic [7:0] model_load();
        if (pend_q.size() > 0) return pend_q.pop_front();
        exp_under++;
        return FILL;
    endfunction

    logic [7:0] cs_hist = 8'hFF;
    int         since_rst = 0;

    always begin
        logic [7:0] e;
        logic       eb;
        @(posedge sysclk);
        #3;
        cs_hist = {cs_hist[6:0], bus.cs_n};
        if (rst) since_rst = 0;
        else if (since_rst < 100) since_rst++;
        if (!rst) begin
            if (bus.rx_valid) begin
                rx_pulses++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: rx_valid with data %0h, none expected", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", bus.rx_data, e);
                end
            end
            if (bus.tx_underrun) under_seen++;
            if (bus.frame_abort) abort_seen++;
            if (since_rst > SYNC + 1) begin
                eb = ~cs_hist[SYNC];
                check("busy", bus.busy, eb);
                check("miso_oe", bus.miso_oe, eb);
            end
            if (!bus.miso_oe) check("miso_idle", bus.miso, 1'b0);
        end
    end

    task automatic push_tx(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge sysclk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        while (!bus.tx_ready && n < 1000) begin
            @(negedge sysclk);
            n++;
        end
        check("push_tx_wait", (n < 1000), 1);
        @(negedge sysclk);
        bus.tx_valid = 1'b0;
        pend_q.push_back(b);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.mosi = v[i];
            repeat (HALF) @(negedge sysclk);
            got[i]  = bus.miso;
            bus.sck = 1'b1;
            repeat (HALF) @(negedge sysclk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge sysclk);
        bus.cs_n    = 1'b0;
        cur_tx      = model_load();
        frame_bytes = 0;
        repeat (HALF) @(negedge sysclk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge sysclk);
        bus.cs_n = 1'b1;
        repeat (2 * HALF) @(negedge sysclk);
        check("byte_count_model", bus.byte_count, frame_bytes);
    endtask

    task automatic xfer_byte(input logic [7:0] rx, output logic [7:0] got);
        exp_q.push_back(rx);
        send_bits(rx, 8, got);
        check("miso_byte", got, cur_tx);
        cur_tx = model_load();
        frame_bytes++;
    endtask

    initial begin
        logic [7:0] got, g1, g2, g3;
        int u0, a0, r0;
        bus.sck      = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (4) @(negedge sysclk);

        check("rst_miso", bus.miso, 1'b0);
        check("rst_miso_oe", bus.miso_oe, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_byte_count", bus.byte_count, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_underrun", bus.tx_underrun, 1'b0);
        check("rst_abort", bus.frame_abort, 1'b0);
        check("rst_state", dbg.state, IDLE);
        rst = 1'b0;
        repeat (4) @(negedge sysclk);

        // Single byte with a preloaded transmit byte.
        r0 = rx_pulses;
        push_tx(8'hA5);
        frame_begin();
        xfer_byte(8'h3C, got);
        frame_end();
        check("t1_miso", got, 8'hA5);
        check("t1_rx_data", bus.rx_data, 8'h3C);
        check("t1_byte_count", bus.byte_count, 16'd1);
        check("t1_rx_pulses", rx_pulses - r0, 1);

        // Three-byte frame; a trailing byte covers the reload after the last byte.
        r0 = rx_pulses;
        u0 = under_seen;
        push_tx(8'h01);
        frame_begin();
        push_tx(8'h02);
        xfer_byte(8'h11, g1);
        push_tx(8'h03);
        xfer_byte(8'h22, g2);
        push_tx(8'h04);
        xfer_byte(8'h33, g3);
        frame_end();
        check("t2_miso0", g1, 8'h01);
        check("t2_miso1", g2, 8'h02);
        check("t2_miso2", g3, 8'h03);
        check("t2_rx_pulses", rx_pulses - r0, 3);
        check("t2_byte_count", bus.byte_count, 16'd3);
        check("t2_underruns", under_seen - u0, 0);

        // Underrun: nothing loaded at cs_n fall.
        u0 = under_seen;
        frame_begin();
        check("t3_underrun_at_cs", under_seen - u0, 1);
        xfer_byte(8'hFF, got);
        frame_end();
        check("t3_miso", got, 8'h00);
        check("t3_rx_data", bus.rx_data, 8'hFF);
        check("t3_underruns", under_seen - u0, 2);

        // Abort after 5 bits, then a clean frame.
        a0 = abort_seen;
        r0 = rx_pulses;
        push_tx(8'h77);
        frame_begin();
        send_bits(8'h15, 5, got);
        exp_abort++;
        frame_end();
        check("t4_partial_miso", got, 8'h17);
        check("t4_abort", abort_seen - a0, 1);
        check("t4_rx_pulses", rx_pulses - r0, 0);
        check("t4_rx_held", bus.rx_data, 8'hFF);
        check("t4_byte_count", bus.byte_count, 16'd0);
        push_tx(8'h96);
        frame_begin();
        xfer_byte(8'hC3, got);
        frame_end();
        check("t4_next_miso", got, 8'h96);
        check("t4_next_rx", bus.rx_data, 8'hC3);

        // Reset in the middle of bit 3.
        a0 = abort_seen;
        r0 = rx_pulses;
        push_tx(8'h33);
        frame_begin();
        send_bits(8'hA9, 3, got);
        @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        check("t5_miso", bus.miso, 1'b0);
        check("t5_miso_oe", bus.miso_oe, 1'b0);
        check("t5_rx_data", bus.rx_data, 8'h00);
        check("t5_rx_valid", bus.rx_valid, 1'b0);
        check("t5_byte_count", bus.byte_count, 16'd0);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_tx_ready", bus.tx_ready, 1'b1);
        check("t5_underrun", bus.tx_underrun, 1'b0);
        check("t5_abort", bus.frame_abort, 1'b0);
        bus.cs_n = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        pend_q.delete();
        repeat (4) @(negedge sysclk);
        check("t5_no_abort", abort_seen - a0, 0);
        check("t5_no_rx", rx_pulses - r0, 0);
        check("t5_still_idle", bus.busy, 1'b0);
        push_tx(8'hC5);
        frame_begin();
        xfer_byte(8'h5A, got);
        frame_end();
        check("t5_miso_after", got, 8'hC5);
        check("t5_rx_after", bus.rx_data, 8'h5A);
        check("t5_count_after", bus.byte_count, 16'd1);

        // Byte offered exactly in the reload cycle goes straight to the shifter.
        u0 = under_seen;
        push_tx(8'h81);
        frame_begin();
        pend_q.push_back(8'hE7);
        xfer_byte(8'h10, g1);
        repeat (SYNC) @(negedge sysclk);
        check("t6_ready_before", bus.tx_ready, 1'b1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hE7;
        @(negedge sysclk);
        bus.tx_valid = 1'b0;
        check("t6_ready_after", bus.tx_ready, 1'b1);
        check("t6_hold_empty", dbg.hold_full, 1'b0);
        xfer_byte(8'h24, g2);
        frame_end();
        check("t6_miso0", g1, 8'h81);
        check("t6_miso1", g2, 8'hE7);
        check("t6_underruns", under_seen - u0, 1);

        repeat (20) @(negedge sysclk);
        check("exp_q_drained", exp_q.size(), 0);
        check("underrun_total", under_seen, exp_under);
        check("abort_total", abort_seen, exp_abort);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
